// File: rtl/nf_instr_mem_ctrl.sv
// nanoFOX instruction-side responder: synchronous-read instruction RAM, byte-stream
// program loader, and the run/halt sequencing that drives the core's cpu_en.
module nf_instr_mem_ctrl #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  output logic        cpu_en,
  input  logic        run,
  input  logic        ld_start,
  input  logic [15:0] ld_len,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_err
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] EXEC  = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [1:0]  byte_cnt_r;
  logic [16:0] word_cnt_r;
  logic [16:0] len_q_r;
  logic [23:0] word_buf_r;
  logic [31:0] instr_r;
  logic        cpu_en_r;
  logic        ld_ready_r;
  logic        ld_done_r;
  logic        ld_err_r;
  logic [31:0] mem_r [DEPTH];

  logic        accept_s;
  logic        word_wr_s;
  logic        load_end_s;
  logic        len_over_s;
  logic        addr_oor_s;
  logic [16:0] len_clip_s;
  logic [31:0] wr_word_s;
  logic        unused_s;

  assign instr    = instr_r;
  assign cpu_en   = cpu_en_r;
  assign ld_ready = ld_ready_r;
  assign ld_done  = ld_done_r;
  assign ld_err   = ld_err_r;
  assign unused_s = &{1'b0, instr_addr[1:0]};

  // Loader handshake, word completion and address range decode
  always_comb begin
    accept_s   = 1'b0;
    word_wr_s  = 1'b0;
    load_end_s = 1'b0;
    len_over_s = ({1'b0, ld_len} > DEPTH_W);
    len_clip_s = len_over_s ? DEPTH_W : {1'b0, ld_len};
    wr_word_s  = {ld_data, word_buf_r};
    addr_oor_s = ({2'b00, instr_addr[31:2]} >= 32'(DEPTH));
    // a restart or reset in the same cycle wins over the byte on the bus
    if (state_r == LOAD && !ld_start && !reset) begin
      accept_s   = ld_valid && (len_q_r != 17'd0);
      word_wr_s  = accept_s && (byte_cnt_r == 2'd3);
      load_end_s = (len_q_r == 17'd0) ||
                   (word_wr_s && (word_cnt_r == len_q_r - 17'd1));
    end else begin
      accept_s   = 1'b0;
      word_wr_s  = 1'b0;
      load_end_s = 1'b0;
    end
  end

  // Run/halt/load sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (ld_start)  state_next_s = LOAD;
        else if (run)  state_next_s = FETCH;
        else           state_next_s = IDLE;
      end
      LOAD: begin
        if (ld_start)        state_next_s = LOAD;
        else if (load_end_s) state_next_s = IDLE;
        else                 state_next_s = LOAD;
      end
      FETCH: begin
        if (ld_start)  state_next_s = LOAD;
        else if (!run) state_next_s = IDLE;
        else           state_next_s = EXEC;
      end
      EXEC: begin
        if (ld_start)  state_next_s = LOAD;
        else if (!run) state_next_s = IDLE;
        else           state_next_s = FETCH;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, registered outputs, loader counters and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      instr_r    <= NOP_INSTR;
      cpu_en_r   <= 1'b0;
      ld_ready_r <= 1'b0;
      ld_done_r  <= 1'b0;
      ld_err_r   <= 1'b0;
      byte_cnt_r <= 2'd0;
      word_cnt_r <= 17'd0;
      len_q_r    <= 17'd0;
      word_buf_r <= 24'd0;
    end else begin
      state_r    <= state_next_s;
      cpu_en_r   <= (state_next_s == EXEC);
      ld_ready_r <= (state_next_s == LOAD);
      ld_done_r  <= load_end_s;
      if (ld_start) begin
        byte_cnt_r <= 2'd0;
        word_cnt_r <= 17'd0;
        len_q_r    <= len_clip_s;
        ld_err_r   <= len_over_s;
      end else if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0:    word_buf_r[7:0]   <= ld_data;
          2'd1:    word_buf_r[15:8]  <= ld_data;
          2'd2:    word_buf_r[23:16] <= ld_data;
          default: word_buf_r        <= word_buf_r;
        endcase
        if (word_wr_s) word_cnt_r <= word_cnt_r + 17'd1;
        else           word_cnt_r <= word_cnt_r;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
      if (state_r == FETCH) instr_r <= addr_oor_s ? NOP_INSTR : mem_r[instr_addr[AW+1:2]];
      else                  instr_r <= instr_r;
    end
  end

  // Instruction RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (word_wr_s) mem_r[word_cnt_r[AW-1:0]] <= wr_word_s;
  end

endmodule

// File: tb/tb_nf_instr_mem_ctrl.sv
// Self-checking bench for nf_instr_mem_ctrl: byte-level load model plus a queue of
// expected instruction words compared whenever the DUT raises cpu_en.
module tb_nf_instr_mem_ctrl;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_addr = 32'd0;
  logic [31:0] instr;
  logic        cpu_en;
  logic        run = 1'b0;
  logic        ld_start = 1'b0;
  logic [15:0] ld_len = 16'd0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] bmem [DEPTH];
  logic [31:0] exp_q [$];
  int          m_lane, m_wc, m_len;
  logic [31:0] m_word;

  nf_instr_mem_ctrl #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr(instr), .cpu_en(cpu_en),
    .run(run), .ld_start(ld_start), .ld_len(ld_len), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    ld_start = 1'b1;
    ld_len   = 16'(len);
    ld_valid = 1'b0;
    step();
    ld_start = 1'b0;
    m_lane = 0;
    m_wc   = 0;
    m_len  = (len > DEPTH) ? DEPTH : len;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit wrote;
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_data  = 8'($urandom);
      step();
    end
    ld_data  = b;
    ld_valid = 1'b1;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_ready_in_load: got %b want 1", ld_ready);
    end
    step();
    ld_valid = 1'b0;
    m_word[8*m_lane +: 8] = b;
    wrote = (m_lane == 3);
    if (wrote) begin
      bmem[m_wc] = m_word;
      m_wc++;
      m_lane = 0;
    end else begin
      m_lane++;
    end
    n_checks++;
    if (ld_done !== (wrote && m_wc == m_len)) begin
      n_fail++;
      $display("FAIL ld_done_after_byte: got %b want %b (word %0d)", ld_done,
               (wrote && m_wc == m_len), m_wc);
    end
  endtask

  // run must already be 1; leaves the DUT in EXEC
  task automatic exec_one(input logic [31:0] addr, input logic [31:0] e);
    logic [31:0] got_exp;
    instr_addr = addr;
    exp_q.push_back(e);
    step();
    n_checks++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_en_fetch: got %b want 0", cpu_en);
    end
    step();
    n_checks++;
    if (cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_en_exec: got %b want 1", cpu_en);
    end
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow at addr %h", addr);
    end else begin
      got_exp = exp_q.pop_front();
      n_checks++;
      if (instr !== got_exp) begin
        n_fail++;
        $display("FAIL instr_exec addr %h: got %h want %h", addr, instr, got_exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    n_checks++;
    if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    n_checks++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_checks++;
    if (ld_done !== 1'b0) begin n_fail++; $display("FAIL reset_ld_done: got %b want 0", ld_done); end
    n_checks++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err: got %b want 0", ld_err); end
  endtask

  task automatic test_load_and_run();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    start_load(2);
    n_checks++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL load_ld_err: got %b want 0", ld_err); end
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    n_checks++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop: got %b want 0", ld_ready); end
    step();
    n_checks++;
    if (ld_done !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse: got %b want 0", ld_done); end
    run = 1'b1;
    exec_one(32'h0, 32'h00100513);
    exec_one(32'h4, 32'h00150593);
    exec_one(32'h0, 32'h00100513);
  endtask

  task automatic test_halt_resume();
    step();
    n_checks++;
    if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_fetch_cpu_en: got %b want 0", cpu_en); end
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (cpu_en !== 1'b0 || instr !== 32'h00100513) begin
        n_fail++;
        $display("FAIL halt_idle: cpu_en %b instr %h want 0 00100513", cpu_en, instr);
      end
    end
    run = 1'b1;
    exec_one(32'h4, 32'h00150593);
  endtask

  task automatic test_out_of_range();
    exec_one(32'h00000400, NOP);
    exec_one(32'h80000000, NOP);
    exec_one(32'h00000007, 32'h00150593);
    run = 1'b0;
    step();
    n_checks++;
    if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL oor_halt_cpu_en: got %b want 0", cpu_en); end
  endtask

  task automatic test_empty_load();
    start_load(0);
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL empty_in_load: got %b want 1", ld_ready); end
    step();
    n_checks++;
    if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: done %b ready %b want 1 0", ld_done, ld_ready);
    end
    step();
  endtask

  task automatic test_overflow();
    start_load(300);
    n_checks++;
    if (ld_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set: got %b want 1", ld_err); end
    for (int i = 0; i < 1024; i++) send_byte(8'(i * 7 + 3), 0);
    n_checks++;
    if (ld_err !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_end: err %b ready %b want 1 0", ld_err, ld_ready);
    end
    step();
    start_load(1);
    n_checks++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %b want 0", ld_err); end
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    step();
    run = 1'b1;
    exec_one(32'h0, 32'hD4C3B2A1);
    exec_one(32'h3FC, bmem[255]);
    exec_one(32'h200, bmem[128]);
    run = 1'b0;
    step();
  endtask

  task automatic test_restart_backpressure();
    start_load(2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    start_load(1);
    send_byte(8'h11, 2);
    send_byte(8'h22, 2);
    send_byte(8'h33, 1);
    send_byte(8'h44, 3);
    step();
    run = 1'b1;
    exec_one(32'h0, 32'h44332211);
    exec_one(32'h4, bmem[1]);
    run = 1'b0;
    step();
  endtask

  task automatic test_interrupt();
    run = 1'b1;
    exec_one(32'h0, 32'h44332211);
    start_load(2);
    n_checks++;
    if (ld_ready !== 1'b1 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL intr_to_load: ready %b cpu_en %b want 1 0", ld_ready, cpu_en);
    end
    send_byte(8'h55, 0);
    send_byte(8'h66, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (ld_ready !== 1'b0 || instr !== NOP || cpu_en !== 1'b0 || ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_load: ready %b instr %h cpu_en %b done %b want 0 %h 0 0",
               ld_ready, instr, cpu_en, ld_done, NOP);
    end
    exec_one(32'h4, bmem[1]);
    exec_one(32'h0, 32'h44332211);
    run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_load_and_run();
    test_halt_resume();
    test_out_of_range();
    test_empty_load();
    test_overflow();
    test_restart_backpressure();
    test_interrupt();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nf_instr_mem_ctrl.md
Name: nf_instr_mem_ctrl

Overview:
Instruction-side responder for the nanoFOX single-cycle core. It answers the core's instruction address with instruction data from an on-chip synchronous-read RAM, and drives the core's cpu_en so each instruction is executed only when valid. It also includes a byte-stream program loader that fills the RAM while the core is halted, and it owns the run/halt sequencing of the core.

Parameters:
DEPTH, 256, instruction RAM depth in 32-bit words (power of two, 4..65536)
NOP_INSTR, 32'h00000013, word returned for out-of-range addresses and after reset (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_addr  in  32  byte address from core PC; bits [1:0] ignored
instr  out  32  instruction data to core
cpu_en  out  1  core enable; 1 for exactly the cycle the core executes
run  in  1  level; 1 = core allowed to execute
ld_start  in  1  single-cycle pulse; begin program load at word 0
ld_len  in  16  number of words to load; sampled with ld_start
ld_data  in  8  load byte, little-endian within each word
ld_valid  in  1  ld_data valid
ld_ready  out  1  loader accepts a byte this cycle
ld_done  out  1  single-cycle pulse; load finished
ld_err  out  1  sticky; ld_len exceeded DEPTH; cleared by the next ld_start or by reset

Behaviour:
- Reset, synchronous and active-high. Values: state=IDLE, instr=NOP_INSTR, cpu_en=0, ld_ready=0, ld_done=0, ld_err=0, byte_cnt=0, word_cnt=0. RAM contents are not reset.
- RAM: one write port and one read port, synchronous read. The read address is instr_addr[31:2].
- An address is out of range when instr_addr[31:2] >= DEPTH. An out-of-range fetch loads NOP_INSTR.
- States: IDLE, LOAD, FETCH, EXEC.
- cpu_en = (state==EXEC). ld_ready = (state==LOAD).
- IDLE:
  - ld_start goes to LOAD. ld_start has priority over run.
  - Otherwise run=1 goes to FETCH.
- FETCH:
  - The RAM is read at instr_addr. The instr register loads the read word (or NOP_INSTR) at the end of the cycle.
  - Next state: LOAD if ld_start; else IDLE if run=0; else EXEC.
- EXEC:
  - cpu_en=1 and instr is stable. The core updates its PC at the end of this cycle.
  - EXEC always completes.
  - Next state: LOAD if ld_start; else IDLE if run=0; else FETCH.
- Throughput: one instruction per 2 cycles. Latency from address to cpu_en is 1 cycle.
- instr changes only at the end of FETCH. It holds its value in IDLE, LOAD and EXEC.
- Entry to LOAD, from any state via ld_start:
  - byte_cnt=0, word_cnt=0, len_q = min(ld_len, DEPTH).
  - ld_err=1 if ld_len > DEPTH, else ld_err=0.
- If len_q==0, LOAD exits to IDLE on the next cycle with a ld_done pulse. No bytes are accepted.
- LOAD byte handling:
  - Each cycle with ld_valid&&ld_ready, the byte goes into lane byte_cnt and byte_cnt increments modulo 4.
  - On the 4th byte, the assembled word (earlier bytes plus the current byte) is written to RAM[word_cnt] in the same cycle, and word_cnt increments.
- When the write of word len_q-1 occurs, the next state is IDLE, ld_done=1 for one cycle, and ld_ready drops on the following cycle.
- ld_start during LOAD restarts the load and discards the partial word. Words already written stay in RAM.
- run is ignored in LOAD. The core resumes only after returning to IDLE with run=1.
- This block never resets the core PC. The system resets the core separately.
- Reset mid-load returns to IDLE. Words written so far stay in RAM, and the partial word is lost.

Test Plan:
- Load and run: reset. Pulse ld_start with ld_len=2, then send bytes 13 05 10 00 93 05 15 00. RAM[0]=32'h00100513 and RAM[1]=32'h00150593. ld_done pulses one cycle after the 8th byte. Then set run=1 with instr_addr=0: FETCH, then EXEC with instr=32'h00100513 and cpu_en=1. cpu_en toggles 0/1 every cycle after that.
- Halt and resume: drop run while in FETCH. State goes to IDLE with cpu_en=0 and instr holding its value. Raise run: fetch resumes at the current instr_addr.
- Out-of-range fetch: DEPTH=256, instr_addr=32'h00000400. In EXEC, instr=32'h00000013.
- Length overflow: pulse ld_start with ld_len=300 at DEPTH=256. ld_err=1. ld_done comes after exactly 1024 bytes. A following ld_start with ld_len=1 clears ld_err.
- Restart and backpressure: in LOAD, send 2 bytes, then pulse ld_start again. byte_cnt=0 and the next 4 bytes form word 0. With ld_valid gaps, bytes are accepted only when ld_valid=1.
- Interrupt: ld_start during EXEC. cpu_en=1 for that cycle, LOAD on the next cycle. Reset in LOAD gives IDLE with ld_ready=0 and instr=NOP_INSTR.
